// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle ripple-carry adder, one 17-bit slice per clock with a registered carry.
// Optional subtract mode (port i_sub) is enabled by defining RCA_SEQ_CTRL_SUB_EN.
module rca_seq_ctrl #(
    parameter int NUM_CHUNKS = 4,
    localparam int W = 17 * NUM_CHUNKS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_add_term1,
    input  logic [W-1:0] i_add_term2,
`ifdef RCA_SEQ_CTRL_SUB_EN
    input  logic         i_sub,
`endif
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W:0]   o_result,
    output logic         o_busy
);
    localparam int KW = $clog2(NUM_CHUNKS);
    localparam int LW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b;
    logic [W:0]      r_result;
    logic            r_carry;
    logic [KW-1:0]   r_k;
    logic            w_sub, w_accept, w_last;
    logic [LW-1:0]   w_lo;
    logic [17:0]     w_s;

`ifdef RCA_SEQ_CTRL_SUB_EN
    assign w_sub = i_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_accept = i_valid && o_ready;
    assign w_last   = r_k == KW'(NUM_CHUNKS - 1);
    assign w_lo     = LW'(17 * r_k);
    assign w_s      = {1'b0, r_a[w_lo +: 17]} + {1'b0, r_b[w_lo +: 17]} + {17'b0, r_carry};
    assign o_ready  = r_state == IDLE;
    assign o_valid  = r_state == DONE;
    assign o_busy   = r_state != IDLE;
    assign o_result = r_result;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = i_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Carry crosses slices only through r_carry, so each cycle sees a single 17-bit adder.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_k      <= '0;
        end else if (w_accept) begin
            r_a      <= i_add_term1;
            r_b      <= w_sub ? ~i_add_term2 : i_add_term2;
            r_result <= '0;
            r_carry  <= w_sub;
            r_k      <= '0;
        end else if (r_state == RUN) begin
            r_result[w_lo +: 17] <= w_s[16:0];
            r_carry              <= w_s[17];
            r_k                  <= w_last ? '0 : r_k + 1'b1;
            if (w_last) r_result[W] <= w_s[17];
        end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed self-checking bench for rca_seq_ctrl at NUM_CHUNKS=4.
module tb_rca_seq_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [67:0] a = '0, b = '0;
    logic        o_ready, o_valid, o_busy;
    logic [68:0] o_result;
    int          checks = 0;
    int          failures = 0;
`ifdef RCA_SEQ_CTRL_SUB_EN
    logic        sub = 1'b0;
`endif

    rca_seq_ctrl #(.NUM_CHUNKS(4)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_add_term1(a),
        .i_add_term2(b),
`ifdef RCA_SEQ_CTRL_SUB_EN
        .i_sub(sub),
`endif
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_result(o_result),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic rdy, input logic vld, input logic bsy);
        chk({tag, "_ready"}, {68'b0, o_ready}, {68'b0, rdy});
        chk({tag, "_valid"}, {68'b0, o_valid}, {68'b0, vld});
        chk({tag, "_busy"}, {68'b0, o_busy}, {68'b0, bsy});
    endtask

    task automatic start(input logic [67:0] ta, input logic [67:0] tb);
        a = ta;
        b = tb;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        #12;
        ctl("reset", 1'b1, 1'b0, 1'b0);
        chk("reset_result", o_result, 69'h0);
        i_rst = 1'b0;
        tick();

        start(68'h1FFFF, 68'h1);
        ctl("t1_run", 1'b0, 1'b0, 1'b1);
        chk("t1_cleared", o_result, 69'h0);
        tick(); tick(); tick();
        chk("t1_not_yet", {68'b0, o_valid}, 69'h0);
        tick();
        ctl("t1_done", 1'b0, 1'b1, 1'b1);
        chk("t1_result", o_result, 69'h20000);
        tick();
        ctl("t1_idle", 1'b1, 1'b0, 1'b0);

        i_ready = 1'b0;
        start(68'hF_FFFF_FFFF_FFFF_FFFF, 68'hF_FFFF_FFFF_FFFF_FFFF);
        chk("t2_cleared", o_result, 69'h0);
        tick(); tick(); tick(); tick();
        chk("t2_result", o_result, 69'h1_FFFF_FFFF_FFFF_FFFF_E);
        for (int i = 0; i < 10; i++) begin
            i_valid = i[0];
            a = {4'h0, 32'(i), 32'h0};
            b = ~a;
            tick();
            ctl("t2_hold", 1'b0, 1'b1, 1'b1);
            chk("t2_hold_result", o_result, 69'h1_FFFF_FFFF_FFFF_FFFF_E);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        ctl("t2_release", 1'b1, 1'b0, 1'b0);

        start(68'hF_FFFF_FFFF_FFFF_FFFF, 68'h1);
        a = 68'h1234;
        b = 68'h5678;
        tick(); tick(); tick(); tick();
        chk("t3_ripple", o_result, 69'h1_0000_0000_0000_0000_0);

        tick();
        start(68'h8_0000_0000_0000_0000, 68'h8_0000_0000_0000_0001);
        tick(); tick(); tick(); tick();
        chk("t4_msb_carry", o_result, 69'h1_0000_0000_0000_0000_1);
        tick();

        start(68'hF_FFFF_FFFF_FFFF_FFFF, 68'hF_FFFF_FFFF_FFFF_FFFF);
        tick(); tick();
        #2 i_rst = 1'b1;
        #1;
        ctl("t5_async_rst", 1'b1, 1'b0, 1'b0);
        chk("t5_rst_result", o_result, 69'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        tick();
        start(68'h3, 68'h4);
        tick(); tick(); tick(); tick();
        ctl("t5_done", 1'b0, 1'b1, 1'b1);
        chk("t5_result", o_result, 69'h7);
        tick();

`ifdef RCA_SEQ_CTRL_SUB_EN
        sub = 1'b1;
        start(68'h5, 68'h7);
        sub = 1'b0;
        tick(); tick(); tick(); tick();
        chk("sub_borrow", o_result, 69'h0_FFFF_FFFF_FFFF_FFFF_E);
        tick();
        sub = 1'b1;
        start(68'h7, 68'h5);
        sub = 1'b0;
        tick(); tick(); tick(); tick();
        chk("sub_noborrow", o_result, 69'h1_0000_0000_0000_0000_2);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
